// File: rtl/wave_segment_sequencer_pkg.sv
// Shared definitions for the waveform segment sequencer: FSM encoding,
// screen limits, drawer-acknowledge guard and the saturating x helper.
package wave_segment_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LATCH     = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_FINISH    = 3'd6
  } seq_state_t;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
  } point_t;

  localparam int unsigned X_MAX     = 319;
  localparam int unsigned Y_MAX     = 239;
  localparam int unsigned ACK_GUARD = 3;
  localparam int unsigned GUARD_W   = 2;

  function automatic logic [8:0] sat_x(input logic [31:0] v);
    return (v > 32'(X_MAX)) ? 9'(X_MAX) : v[8:0];
  endfunction

endpackage

// File: rtl/wave_segment_sequencer_if.sv
// Bundles the control, sample-buffer and line-drawer signals of the sequencer.
interface wave_segment_sequencer_if #(
  parameter int NUM_POINTS = 64
);
  localparam int AW = $clog2(NUM_POINTS);

  logic                start;
  logic [8:0]          thickness_in;
  logic                busy;
  logic                frame_done;
  logic                sample_rd;
  logic [AW-1:0]       sample_addr;
  logic signed [15:0]  sample_data;
  logic                Go;
  logic [8:0]          X0;
  logic [8:0]          X1;
  logic [7:0]          Y0;
  logic [7:0]          Y1;
  logic [8:0]          Thickness;
  logic                Done;

  modport master (
    input  start, thickness_in, sample_data, Done,
    output busy, frame_done, sample_rd, sample_addr,
    output Go, X0, X1, Y0, Y1, Thickness
  );

  modport slave (
    output start, thickness_in, sample_data, Done,
    input  busy, frame_done, sample_rd, sample_addr,
    input  Go, X0, X1, Y0, Y1, Thickness
  );
endinterface

// File: rtl/wave_segment_sequencer_sample_to_row.sv
// Converts a signed sample into a screen row: scale by arithmetic shift,
// offset from the centre line and clamp to the visible rows.
module sample_to_row
  import wave_segment_sequencer_pkg::*;
#(
  parameter int Y_CENTER  = 120,
  parameter int AMP_SHIFT = 8
) (
  input  logic signed [15:0] i_sample,
  output logic [7:0]         o_row
);
  localparam logic signed [16:0] Y_C = 17'(Y_CENTER);

  logic signed [15:0] w_shifted;
  logic signed [16:0] w_diff;

  // 17-bit signed difference keeps full-scale samples from wrapping
  always_comb begin
    w_shifted = i_sample >>> AMP_SHIFT;
    w_diff    = Y_C - $signed({w_shifted[15], w_shifted});
    if (w_diff < 17'sd0) begin
      o_row = 8'd0;
    end else if (w_diff > $signed(17'(Y_MAX))) begin
      o_row = 8'(Y_MAX);
    end else begin
      o_row = w_diff[7:0];
    end
  end
endmodule

// File: rtl/wave_segment_sequencer.sv
// Walks the sample buffer once per frame and issues one thick-line segment
// per consecutive pair of points to the line drawer.
module wave_segment_sequencer
  import wave_segment_sequencer_pkg::*;
#(
  parameter int NUM_POINTS = 64,
  parameter int X_STEP     = 5,
  parameter int X_ORIGIN   = 0,
  parameter int Y_CENTER   = 120,
  parameter int AMP_SHIFT  = 8
) (
  input logic                       clk,
  input logic                       reset,
  wave_segment_sequencer_if.master  bus
);
  localparam int              AW       = $clog2(NUM_POINTS);
  localparam logic [AW-1:0]   LAST_IDX = AW'(NUM_POINTS - 1);
  localparam logic [8:0]      X_START  = sat_x(32'(X_ORIGIN));

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic                w_complete;
  logic                w_last;
  logic [GUARD_W-1:0]  r_guard;
  logic [AW-1:0]       r_idx;
  logic [AW-1:0]       r_addr;
  logic [8:0]          r_xacc;
  logic [8:0]          w_xacc_inc;
  logic [7:0]          w_row;
  point_t              w_pt;
  point_t              r_cur;
  point_t              r_prev;
  logic [8:0]          r_thick;
  logic                r_rd;
  logic                r_go;
  logic                r_busy;
  logic                r_fdone;

  sample_to_row #(
    .Y_CENTER  (Y_CENTER),
    .AMP_SHIFT (AMP_SHIFT)
  ) u_row (
    .i_sample (bus.sample_data),
    .o_row    (w_row)
  );

  assign w_last     = (r_idx == LAST_IDX);
  assign w_xacc_inc = sat_x(32'(r_xacc) + 32'(X_STEP));
  assign w_pt       = '{x: r_xacc, y: w_row};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A segment completes on the drawer's Done edge or after the skip guard expires
  always_comb begin
    w_state_nxt = r_state;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: w_state_nxt = ST_LATCH;
      ST_LATCH: begin
        if (r_idx == {AW{1'b0}}) begin
          w_state_nxt = ST_FETCH;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_go) begin
          w_state_nxt = ST_WAIT_ACK;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT_ACK: begin
        if (!bus.Done) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_guard == GUARD_W'(ACK_GUARD - 1)) begin
          w_complete  = 1'b1;
          w_state_nxt = w_last ? ST_FINISH : ST_FETCH;
        end else begin
          w_state_nxt = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.Done) begin
          w_complete  = 1'b1;
          w_state_nxt = w_last ? ST_FINISH : ST_FETCH;
        end else begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Go is only raised when the drawer reported idle on the preceding edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_guard <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_xacc  <= 9'd0;
      r_cur   <= '0;
      r_prev  <= '0;
      r_thick <= 9'd0;
      r_rd    <= 1'b0;
      r_go    <= 1'b0;
      r_busy  <= 1'b0;
      r_fdone <= 1'b0;
    end else begin
      r_rd    <= (w_state_nxt == ST_FETCH);
      r_go    <= (w_state_nxt == ST_ISSUE) && bus.Done && !r_go;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_fdone <= (w_state_nxt == ST_FINISH);

      if ((r_state == ST_WAIT_ACK) && bus.Done) begin
        r_guard <= r_guard + GUARD_W'(1);
      end else begin
        r_guard <= '0;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_thick <= bus.thickness_in;
            r_idx   <= '0;
            r_addr  <= '0;
            r_xacc  <= X_START;
          end
        end
        ST_LATCH: begin
          r_cur <= w_pt;
          if (r_idx == {AW{1'b0}}) begin
            r_prev <= w_pt;
            r_idx  <= r_idx + AW'(1);
            r_addr <= r_idx + AW'(1);
            r_xacc <= w_xacc_inc;
          end
        end
        default: begin
        end
      endcase

      if (w_complete) begin
        r_prev <= r_cur;
        r_idx  <= r_idx + AW'(1);
        r_addr <= r_idx + AW'(1);
        r_xacc <= w_xacc_inc;
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.frame_done  = r_fdone;
  assign bus.sample_rd   = r_rd;
  assign bus.sample_addr = r_addr;
  assign bus.Go          = r_go;
  assign bus.X0          = r_prev.x;
  assign bus.Y0          = r_prev.y;
  assign bus.X1          = r_cur.x;
  assign bus.Y1          = r_cur.y;
  assign bus.Thickness   = r_thick;
endmodule
